// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// pipeline writeback and late results (miss return, mul/div). Late results
// queue in a small FIFO, older buffered writes to a register are squashed by
// a younger pipeline write, and an age counter stops the FIFO head from
// starving behind a continuously busy pipeline.
// Optional: define WB_ARB_FWD_EN to add the q_reg/q_hit/q_data bypass lookup.
module wb_port_arbiter #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int DEPTH   = 2,
    parameter int AGE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p_valid,
    input  logic [REG_AW-1:0]       p_reg,
    input  logic [DATA_W-1:0]       p_data,
    output logic                    p_ready,
    input  logic                    m_valid,
    input  logic [REG_AW-1:0]       m_reg,
    input  logic [DATA_W-1:0]       m_data,
    output logic                    m_ready,
    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_wreg,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [$clog2(DEPTH):0]  buf_cnt
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [REG_AW-1:0]       q_reg,
    output logic                    q_hit,
    output logic [DATA_W-1:0]       q_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = 4;

    logic [DEPTH-1:0]   ent_live;
    logic [REG_AW-1:0]  ent_reg  [DEPTH];
    logic [DATA_W-1:0]  ent_data [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [AGE_W-1:0]   age;

    logic               empty;
    logic               full;
    logic               head_live;
    logic               age_done;
    logic               forced;
    logic               dead_due;
    logic               p_grant;
    logic               b_grant;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic [REG_AW-1:0]  wr_reg;
    logic [DATA_W-1:0]  wr_data;

    // Grant decision: forced head, then pipeline, then buffer when pipeline idle
    always_comb begin
        empty     = (count == '0);
        full      = (count == CNT_W'(DEPTH));
        head_live = !empty && ent_live[head];
        age_done  = (age == AGE_W'(AGE_MAX));
        forced    = head_live && age_done;
        // A squashed head that has aged out is dropped without using the
        // write port, so the pipeline keeps flowing in the same cycle.
        dead_due  = !empty && !ent_live[head] && age_done;
        p_grant   = p_valid && !forced;
        b_grant   = !forced && !p_valid && !empty;
        pop       = forced || b_grant || dead_due;
        push      = m_valid && !full;
        p_ready   = !forced;
        m_ready   = !full;
        buf_cnt   = count;

        wr_en   = 1'b0;
        wr_reg  = ent_reg[head];
        wr_data = ent_data[head];
        if (forced) begin
            wr_en = 1'b1;
        end else if (p_grant) begin
            wr_en   = 1'b1;
            wr_reg  = p_reg;
            wr_data = p_data;
        end else if (b_grant && head_live) begin
            wr_en = 1'b1;
        end
    end

    // Entry live bits: WAW squash, clear on pop, set on push (push slot is never present)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_live <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (p_grant && ent_live[i] && (ent_reg[i] == p_reg)) begin
                    ent_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_live[head] <= 1'b0;
            end
            if (push) begin
                ent_live[tail] <= 1'b1;
            end
        end
    end

    // Entry payload storage, written at the tail on push
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[tail]  <= m_reg;
            ent_data[tail] <= m_data;
        end
    end

    // FIFO pointers, occupancy and head age
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            age   <= '0;
        end else begin
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop || empty) begin
                age <= '0;
            end else if (!age_done) begin
                age <= age + AGE_W'(1);
            end
        end
    end

    // Registered register-file write port; index/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_wreg  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_wreg  <= wr_reg;
                rf_wdata <= wr_data;
            end
        end
    end

`ifdef WB_ARB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Bypass lookup: scan oldest to youngest so the youngest live match wins
    always_comb begin
        q_hit   = 1'b0;
        q_data  = '0;
        fwd_idx = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && ent_live[fwd_idx] && (ent_reg[fwd_idx] == q_reg)) begin
                q_hit  = 1'b1;
                q_data = ent_data[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter (DEPTH=2, AGE_MAX=3). Per-cycle vectors carry
// inputs, expected pre-edge status and the expected rf_* result of that cycle;
// the rf expectation is queued when the vector is driven and compared one
// cycle later when the registered port shows it.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid;
    logic [2:0]  p_reg;
    logic [15:0] p_data;
    logic        p_ready;
    logic        m_valid;
    logic [2:0]  m_reg;
    logic [15:0] m_data;
    logic        m_ready;
    logic        rf_we;
    logic [2:0]  rf_wreg;
    logic [15:0] rf_wdata;
    logic [1:0]  buf_cnt;
`ifdef WB_ARB_FWD_EN
    logic [2:0]  q_reg;
    logic        q_hit;
    logic [15:0] q_data;
`endif

    wb_port_arbiter #(
        .DATA_W (16),
        .REG_AW (3),
        .DEPTH  (2),
        .AGE_MAX(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p_valid (p_valid),
        .p_reg   (p_reg),
        .p_data  (p_data),
        .p_ready (p_ready),
        .m_valid (m_valid),
        .m_reg   (m_reg),
        .m_data  (m_data),
        .m_ready (m_ready),
        .rf_we   (rf_we),
        .rf_wreg (rf_wreg),
        .rf_wdata(rf_wdata),
        .buf_cnt (buf_cnt)
`ifdef WB_ARB_FWD_EN
        ,
        .q_reg   (q_reg),
        .q_hit   (q_hit),
        .q_data  (q_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [2:0]  preg;
        logic [15:0] pdata;
        logic        mv;
        logic [2:0]  mreg;
        logic [15:0] mdata;
        logic        epr;
        logic        emr;
        logic [1:0]  ecnt;
        logic        ewe;
        logic [2:0]  ewreg;
        logic [15:0] ewdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        int          idx;
    } rf_exp_t;

    vec_t    vecs[$];
    rf_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      vnum   = 0;

    function automatic vec_t mk(input logic pv, input logic [2:0] preg, input logic [15:0] pdata,
                                input logic mv, input logic [2:0] mreg, input logic [15:0] mdata,
                                input logic epr, input logic emr, input logic [1:0] ecnt,
                                input logic ewe, input logic [2:0] ewreg, input logic [15:0] ewdata);
        vec_t v;
        v.pv = pv; v.preg = preg; v.pdata = pdata;
        v.mv = mv; v.mreg = mreg; v.mdata = mdata;
        v.epr = epr; v.emr = emr; v.ecnt = ecnt;
        v.ewe = ewe; v.ewreg = ewreg; v.ewdata = ewdata;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the registered write port against the oldest queued expectation
    task automatic check_rf();
        rf_exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk($sformatf("v%0d rf_we", e.idx), int'(rf_we), int'(e.we));
        if (e.we) begin
            chk($sformatf("v%0d rf_wreg", e.idx), int'(rf_wreg), int'(e.wreg));
            chk($sformatf("v%0d rf_wdata", e.idx), int'(rf_wdata), int'(e.wdata));
        end
    endtask

    // One clock cycle: entered and left at a negedge
    task automatic cycle(input vec_t v);
        rf_exp_t e;
        check_rf();
        chk($sformatf("v%0d p_ready", vnum), int'(p_ready), int'(v.epr));
        chk($sformatf("v%0d m_ready", vnum), int'(m_ready), int'(v.emr));
        chk($sformatf("v%0d buf_cnt", vnum), int'(buf_cnt), int'(v.ecnt));
        p_valid = v.pv; p_reg = v.preg; p_data = v.pdata;
        m_valid = v.mv; m_reg = v.mreg; m_data = v.mdata;
        e.we = v.ewe; e.wreg = v.ewreg; e.wdata = v.ewdata; e.idx = vnum;
        sb.push_back(e);
        vnum++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p_valid = 1'b0; p_reg = '0; p_data = '0;
        m_valid = 1'b0; m_reg = '0; m_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
`ifdef WB_ARB_FWD_EN
        q_reg = 3'd5;
`endif

        // Late only: R3 <= 00A5 through the buffer
        vecs.push_back(mk(0,0,16'h0000, 1,3,16'h00A5, 1,1,0, 0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,1, 1,3,16'h00A5));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,0, 0,0,16'h0000));
        // WAW squash: buffered R4=DEAD killed by pipeline R4=BEEF, then dead pop
        vecs.push_back(mk(0,0,16'h0000, 1,4,16'hDEAD, 1,1,0, 0,0,16'h0000));
        vecs.push_back(mk(1,4,16'hBEEF, 0,0,16'h0000, 1,1,1, 1,4,16'hBEEF));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,1, 0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,0, 0,0,16'h0000));
        // Starvation: R2=1111 waits 3 cycles behind a busy pipeline
        vecs.push_back(mk(1,1,16'h0101, 1,2,16'h1111, 1,1,0, 1,1,16'h0101));
        vecs.push_back(mk(1,1,16'h0102, 0,0,16'h0000, 1,1,1, 1,1,16'h0102));
        vecs.push_back(mk(1,1,16'h0103, 0,0,16'h0000, 1,1,1, 1,1,16'h0103));
        vecs.push_back(mk(1,1,16'h0104, 0,0,16'h0000, 1,1,1, 1,1,16'h0104));
        vecs.push_back(mk(1,1,16'h0105, 0,0,16'h0000, 0,1,1, 1,2,16'h1111));
        vecs.push_back(mk(1,1,16'h0105, 0,0,16'h0000, 1,1,0, 1,1,16'h0105));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,0, 0,0,16'h0000));
        // Full buffer: third late result (R7) held until a pop, order kept
        vecs.push_back(mk(1,1,16'h0201, 1,5,16'h0A0A, 1,1,0, 1,1,16'h0201));
        vecs.push_back(mk(1,1,16'h0202, 1,6,16'h0B0B, 1,1,1, 1,1,16'h0202));
        vecs.push_back(mk(1,1,16'h0203, 1,7,16'h0C0C, 1,0,2, 1,1,16'h0203));
        vecs.push_back(mk(1,1,16'h0204, 1,7,16'h0C0C, 1,0,2, 1,1,16'h0204));
        vecs.push_back(mk(1,1,16'h0205, 1,7,16'h0C0C, 0,0,2, 1,5,16'h0A0A));
        vecs.push_back(mk(1,1,16'h0205, 1,7,16'h0C0C, 1,1,1, 1,1,16'h0205));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,0,2, 1,6,16'h0B0B));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,1, 1,7,16'h0C0C));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,0, 0,0,16'h0000));

        repeat (2) @(negedge clk);
        chk("reset rf_we", int'(rf_we), 0);
        chk("reset rf_wreg", int'(rf_wreg), 0);
        chk("reset rf_wdata", int'(rf_wdata), 0);
        chk("reset buf_cnt", int'(buf_cnt), 0);
        chk("reset p_ready", int'(p_ready), 1);
        chk("reset m_ready", int'(m_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i]);
        end
        check_rf();

        // Asynchronous reset with two live entries buffered
        cycle(mk(1,1,16'h0301, 1,3,16'h3333, 1,1,0, 1,1,16'h0301));
        cycle(mk(1,1,16'h0302, 1,4,16'h4444, 1,1,1, 1,1,16'h0302));
        check_rf();
        chk("pre-reset buf_cnt", int'(buf_cnt), 2);
        chk("pre-reset m_ready", int'(m_ready), 0);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("async rst rf_we", int'(rf_we), 0);
        chk("async rst buf_cnt", int'(buf_cnt), 0);
        chk("async rst m_ready", int'(m_ready), 1);
        chk("async rst p_ready", int'(p_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,0, 0,0,16'h0000));
        check_rf();

`ifdef WB_ARB_FWD_EN
        // Bypass: youngest R5 entry forwarded, squash removes both
        cycle(mk(1,1,16'h0501, 1,5,16'h0001, 1,1,0, 1,1,16'h0501));
        cycle(mk(1,1,16'h0502, 1,5,16'h0002, 1,1,1, 1,1,16'h0502));
        q_reg = 3'd5;
        #1;
        chk("fwd q_hit", int'(q_hit), 1);
        chk("fwd q_data", int'(q_data), 16'h0002);
        #1;
        cycle(mk(1,5,16'h0503, 0,0,16'h0000, 1,0,2, 1,5,16'h0503));
        chk("fwd squash q_hit", int'(q_hit), 0);
        cycle(mk(0,0,16'h0000, 0,0,16'h0000, 1,0,2, 0,0,16'h0000));
        cycle(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,1, 0,0,16'h0000));
        cycle(mk(0,0,16'h0000, 0,0,16'h0000, 1,1,0, 0,0,16'h0000));
        check_rf();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
